// File: rtl/vga_pkg.sv
//------------------------------------------------------------------------------
// vga_pkg
// Shared timing record, the 640x480@60 defaults and a helper for axis totals.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package vga_pkg;

    typedef struct packed {
        int active;
        int fp;
        int sync;
        int bp;
    } vga_timing_t;

    localparam vga_timing_t VGA_640X480_H = '{active: 640, fp: 16, sync: 96, bp: 48};
    localparam vga_timing_t VGA_640X480_V = '{active: 480, fp: 10, sync: 2,  bp: 33};

    function automatic int total(input vga_timing_t t);
        return t.active + t.fp + t.sync + t.bp;
    endfunction

endpackage

`default_nettype wire

// File: rtl/vga_timing_gen_axis.sv
//------------------------------------------------------------------------------
// vga_axis_counter
// Modulo-TOTAL position counter for one raster axis with a wrap strobe.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int WIDTH = 10,
    parameter int TOTAL = 800
) (
    input  logic             clk_pixel,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(TOTAL - 1);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Explicit compare against LAST so non-power-of-two totals wrap correctly.
    always_comb begin
        wrap  = inc && (cnt_q == LAST);
        cnt_d = cnt_q;
        if (wrap) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

`default_nettype wire

// File: rtl/vga_timing_gen.sv
//------------------------------------------------------------------------------
// vga_timing_gen
// Parametrised VGA/DVI raster timing generator with aligned registered outputs.
// Optional macro VGA_TIMING_LOOKAHEAD_EN adds next_x/next_y/next_de.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int CW       = 10,
    parameter int H_ACTIVE = VGA_640X480_H.active,
    parameter int H_FP     = VGA_640X480_H.fp,
    parameter int H_SYNC   = VGA_640X480_H.sync,
    parameter int H_BP     = VGA_640X480_H.bp,
    parameter int V_ACTIVE = VGA_640X480_V.active,
    parameter int V_FP     = VGA_640X480_V.fp,
    parameter int V_SYNC   = VGA_640X480_V.sync,
    parameter int V_BP     = VGA_640X480_V.bp,
    parameter int H_POL    = 0,
    parameter int V_POL    = 0
) (
    input  logic          clk_pixel,
    input  logic          rst_n,
    input  logic          en,
    output logic [CW-1:0] screen_x,
    output logic [CW-1:0] screen_y,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic          line_start,
    output logic          frame_start,
    output logic          vblank_start
`ifdef VGA_TIMING_LOOKAHEAD_EN
   ,output logic [CW-1:0] next_x,
    output logic [CW-1:0] next_y,
    output logic          next_de
`endif
);

    localparam int     H_TOTAL    = total(vga_timing_t'{H_ACTIVE, H_FP, H_SYNC, H_BP});
    localparam int     V_TOTAL    = total(vga_timing_t'{V_ACTIVE, V_FP, V_SYNC, V_BP});
    localparam int     H_SYNC_BEG = H_ACTIVE + H_FP;
    localparam int     H_SYNC_END = H_SYNC_BEG + H_SYNC;
    localparam int     V_SYNC_BEG = V_ACTIVE + V_FP;
    localparam int     V_SYNC_END = V_SYNC_BEG + V_SYNC;
    localparam longint CW_SPAN    = longint'(1) << CW;
    localparam logic   H_LVL      = (H_POL != 0);
    localparam logic   V_LVL      = (V_POL != 0);

    generate
        if (CW_SPAN < H_TOTAL || CW_SPAN < V_TOTAL) begin : g_cw_check
            $error("vga_timing_gen: CW too narrow for H_TOTAL/V_TOTAL");
        end
    endgenerate

    logic [CW-1:0] h_cnt;
    logic [CW-1:0] v_cnt;
    logic          h_wrap;
    logic          v_wrap_unused;

    vga_axis_counter #(.WIDTH(CW), .TOTAL(H_TOTAL)) u_h_cnt (
        .clk_pixel (clk_pixel),
        .rst_n     (rst_n),
        .inc       (en),
        .cnt       (h_cnt),
        .wrap      (h_wrap)
    );

    vga_axis_counter #(.WIDTH(CW), .TOTAL(V_TOTAL)) u_v_cnt (
        .clk_pixel (clk_pixel),
        .rst_n     (rst_n),
        .inc       (h_wrap),
        .cnt       (v_cnt),
        .wrap      (v_wrap_unused)
    );

    int   w_h;
    int   w_v;
    logic w_active;
    logic w_hs_on;
    logic w_vs_on;

    assign w_h      = 32'(h_cnt);
    assign w_v      = 32'(v_cnt);
    assign w_active = (w_h < H_ACTIVE) && (w_v < V_ACTIVE);
    assign w_hs_on  = (w_h >= H_SYNC_BEG) && (w_h < H_SYNC_END);
    assign w_vs_on  = (w_v >= V_SYNC_BEG) && (w_v < V_SYNC_END);

    logic [CW-1:0] screen_x_q, screen_x_d;
    logic [CW-1:0] screen_y_q, screen_y_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          de_q, de_d;
    logic          line_start_q, line_start_d;
    logic          frame_start_q, frame_start_d;
    logic          vblank_start_q, vblank_start_d;

    // All outputs sample the pre-increment coordinate so they stay mutually aligned.
    always_comb begin
        screen_x_d     = screen_x_q;
        screen_y_d     = screen_y_q;
        hsync_d        = hsync_q;
        vsync_d        = vsync_q;
        de_d           = de_q;
        line_start_d   = 1'b0;
        frame_start_d  = 1'b0;
        vblank_start_d = 1'b0;
        if (en) begin
            screen_x_d     = h_cnt;
            screen_y_d     = v_cnt;
            de_d           = w_active;
            hsync_d        = w_hs_on ? H_LVL : ~H_LVL;
            vsync_d        = w_vs_on ? V_LVL : ~V_LVL;
            line_start_d   = (w_h == 0);
            frame_start_d  = (w_h == 0) && (w_v == 0);
            vblank_start_d = (w_h == 0) && (w_v == V_ACTIVE);
        end
    end

    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            screen_x_q     <= '0;
            screen_y_q     <= '0;
            hsync_q        <= ~H_LVL;
            vsync_q        <= ~V_LVL;
            de_q           <= 1'b0;
            line_start_q   <= 1'b0;
            frame_start_q  <= 1'b0;
            vblank_start_q <= 1'b0;
        end else begin
            screen_x_q     <= screen_x_d;
            screen_y_q     <= screen_y_d;
            hsync_q        <= hsync_d;
            vsync_q        <= vsync_d;
            de_q           <= de_d;
            line_start_q   <= line_start_d;
            frame_start_q  <= frame_start_d;
            vblank_start_q <= vblank_start_d;
        end
    end

    assign screen_x     = screen_x_q;
    assign screen_y     = screen_y_q;
    assign hsync        = hsync_q;
    assign vsync        = vsync_q;
    assign de           = de_q;
    assign line_start   = line_start_q;
    assign frame_start  = frame_start_q;
    assign vblank_start = vblank_start_q;

`ifdef VGA_TIMING_LOOKAHEAD_EN
    // The live counters are exactly what the registers will show after the next en edge.
    assign next_x  = h_cnt;
    assign next_y  = v_cnt;
    assign next_de = w_active;
`endif

endmodule

`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
//------------------------------------------------------------------------------
// tb_vga_timing_gen
// Directed bench: a tiny 12x7 raster and the default 800x525 raster side by side.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;

    always #5 clk = ~clk;

    logic [3:0] s_x, s_y;
    logic       s_hs, s_vs, s_de, s_ls, s_fs, s_vb;
    logic [9:0] d_x, d_y;
    logic       d_hs, d_vs, d_de, d_ls, d_fs, d_vb;
`ifdef VGA_TIMING_LOOKAHEAD_EN
    logic [3:0] s_nx, s_ny;
    logic       s_nde;
    logic [9:0] d_nx, d_ny;
    logic       d_nde;
`endif

    vga_timing_gen #(
        .CW(4), .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .H_POL(1), .V_POL(1)
    ) u_dut_s (
        .clk_pixel(clk), .rst_n(rst_n), .en(en),
        .screen_x(s_x), .screen_y(s_y), .hsync(s_hs), .vsync(s_vs), .de(s_de),
        .line_start(s_ls), .frame_start(s_fs), .vblank_start(s_vb)
`ifdef VGA_TIMING_LOOKAHEAD_EN
       ,.next_x(s_nx), .next_y(s_ny), .next_de(s_nde)
`endif
    );

    vga_timing_gen u_dut_d (
        .clk_pixel(clk), .rst_n(rst_n), .en(en),
        .screen_x(d_x), .screen_y(d_y), .hsync(d_hs), .vsync(d_vs), .de(d_de),
        .line_start(d_ls), .frame_start(d_fs), .vblank_start(d_vb)
`ifdef VGA_TIMING_LOOKAHEAD_EN
       ,.next_x(d_nx), .next_y(d_ny), .next_de(d_nde)
`endif
    );

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic en;
        int   x;
        int   y;
        logic de, hs, vs, ls, fs, vb;
    } vec_t;

    vec_t tbl[17];

    task automatic step(input logic e);
        en = e;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_s(input string name, input int ex, input int ey,
                         input logic ede, input logic ehs, input logic evs,
                         input logic els, input logic efs, input logic evb);
        logic [13:0] got;
        logic [13:0] exp;
        got = {s_x, s_y, s_de, s_hs, s_vs, s_ls, s_fs, s_vb};
        exp = {4'(ex), 4'(ey), ede, ehs, evs, els, efs, evb};
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got x=%0d y=%0d de/hs/vs/ls/fs/vb=%b, want x=%0d y=%0d de/hs/vs/ls/fs/vb=%b",
                     name, s_x, s_y, got[5:0], ex, ey, exp[5:0]);
        end
    endtask

    task automatic chk_d(input string name, input int ex, input int ey,
                         input logic ede, input logic ehs, input logic evs,
                         input logic els, input logic efs, input logic evb);
        logic [25:0] got;
        logic [25:0] exp;
        got = {d_x, d_y, d_de, d_hs, d_vs, d_ls, d_fs, d_vb};
        exp = {10'(ex), 10'(ey), ede, ehs, evs, els, efs, evb};
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got x=%0d y=%0d de/hs/vs/ls/fs/vb=%b, want x=%0d y=%0d de/hs/vs/ls/fs/vb=%b",
                     name, d_x, d_y, got[5:0], ex, ey, exp[5:0]);
        end
    endtask

    initial begin
        int   mx, my, dx, dy, hs_low, de_cnt;
        int   ex, ey;
        logic ede, ehs, evs, els, efs, evb, e;

        //           en    x   y   de    hs    vs    ls    fs    vb
        tbl[0]  = '{1'b1,  0,  0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[1]  = '{1'b0,  0,  0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0,  0,  0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b1,  1,  0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{1'b1,  2,  0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{1'b1,  3,  0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{1'b1,  4,  0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{1'b1,  5,  0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{1'b1,  6,  0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{1'b1,  7,  0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{1'b1,  8,  0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{1'b1,  9,  0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{1'b0,  9,  0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[13] = '{1'b1, 10,  0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[14] = '{1'b1, 11,  0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[15] = '{1'b1,  0,  1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[16] = '{1'b0,  0,  1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        // Reset state: small raster has active-high syncs, default has active-low.
        #23;
        chk_s("reset_s", 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_d("reset_d", 0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            step(tbl[i].en);
            chk_s($sformatf("vec%0d", i), tbl[i].x, tbl[i].y, tbl[i].de, tbl[i].hs,
                  tbl[i].vs, tbl[i].ls, tbl[i].fs, tbl[i].vb);
        end

        // Asynchronous reset mid-frame, observed before any clock edge.
        #2 rst_n = 1'b0;
        #1;
        chk_s("async_rst_s", 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_d("async_rst_d", 0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        #2 rst_n = 1'b1;

        // en toggling 1/0 over two full small frames against a reference model.
        mx = 0; my = 0;
        ex = 0; ey = 0; ede = 1'b0; ehs = 1'b0; evs = 1'b0;
        for (int k = 0; k < 2 * 84 * 2 + 2; k++) begin
            e = (k % 2 == 0);
            els = 1'b0; efs = 1'b0; evb = 1'b0;
            if (e) begin
                ex  = mx;
                ey  = my;
                ede = (mx < 8) && (my < 4);
                ehs = (mx >= 9) && (mx <= 10);
                evs = (my == 5);
                els = (mx == 0);
                efs = (mx == 0) && (my == 0);
                evb = (mx == 0) && (my == 4);
                mx++;
                if (mx == 12) begin
                    mx = 0;
                    my = (my + 1) % 7;
                end
            end
            step(e);
            chk_s($sformatf("tog%0d", k), ex, ey, ede, ehs, evs, els, efs, evb);
`ifdef VGA_TIMING_LOOKAHEAD_EN
            vectors++;
            if ({s_nx, s_ny, s_nde} !== {4'(mx), 4'(my), logic'((mx < 8) && (my < 4))}) begin
                miscompares++;
                $display("FAIL look%0d: got next=(%0d,%0d,%b), want (%0d,%0d)",
                         k, s_nx, s_ny, s_nde, mx, my);
            end
`endif
        end

        // Default 640x480 timing across the first two lines.
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        dx = 0; dy = 0; hs_low = 0; de_cnt = 0;
        for (int k = 0; k < 1700; k++) begin
            step(1'b1);
            chk_d($sformatf("def%0d", k), dx, dy,
                  (dx < 640) && (dy < 480),
                  !((dx >= 656) && (dx <= 751)),
                  !((dy >= 490) && (dy <= 491)),
                  (dx == 0), (dx == 0) && (dy == 0), (dx == 0) && (dy == 480));
            if (k < 800) begin
                if (d_hs == 1'b0) hs_low++;
                if (d_de == 1'b1) de_cnt++;
            end
            dx++;
            if (dx == 800) begin
                dx = 0;
                dy = (dy + 1) % 525;
            end
        end
        vectors++;
        if (hs_low != 96) begin
            miscompares++;
            $display("FAIL hsync_width: got %0d low cycles, want 96", hs_low);
        end
        vectors++;
        if (de_cnt != 640) begin
            miscompares++;
            $display("FAIL de_per_line: got %0d, want 640", de_cnt);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
